pcm_i2s_tx: RTL

Stereo PCM-to-I2S serializer that consumes the 16-bit decimated PCM samples produced by the per-channel CIC decimators.
- Accepts one left/right sample pair per in_valid strobe, typically pulsed by the en_pcm tick of the audio clock generator.
- Buffers pairs in a small frame FIFO.
- Generates BCLK/LRCLK locally and shifts the samples out in Philips I2S format to an external codec or DAC.
- Input side has no backpressure; overflow and underflow are flagged.

---
 rtl/pcm_i2s_tx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pcm_i2s_tx.sv
//-----------------------------------------------------------------------------
// pcm_i2s_tx
//
// Stereo PCM-to-I2S serializer. Left/right sample pairs from the CIC
// decimators are queued in a small frame FIFO and shifted out MSB-first in
// Philips I2S format. BCLK and LRCLK are generated locally from clk.
//
// Build option:
//   PCM_I2S_TX_REPEAT_EN  - when defined, an underflowing frame repeats the
//                           last popped stereo pair (0/0 if none since
//                           reset) instead of sending silence.
//
// Parameters:
//   W         sample width in bits (1..SLOT)
//   SLOT      BCLK cycles per channel slot
//   BCLK_DIV  clk cycles per BCLK half-period (>=1)
//   DEPTH     FIFO depth in stereo frames, power of 2 (>=2)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   in_valid    single-cycle strobe, pushes {in_left,in_right}
//   in_left     signed left PCM sample
//   in_right    signed right PCM sample
//   clr_flags   clears the overflow/underflow sticky flags
//   i2s_bclk    bit clock
//   i2s_lrclk   word select (0=left, 1=right)
//   i2s_sd      serial data, changes only on BCLK falling edges
//   fifo_level  frames currently buffered
//   overflow    sticky: push dropped while FIFO full
//   underflow   sticky: frame started with FIFO empty
//-----------------------------------------------------------------------------
module pcm_i2s_tx #(
  parameter int W        = 16,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 4,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [W-1:0]         in_left,
  input  logic signed [W-1:0]         in_right,
  input  logic                        clr_flags,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sd,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * SLOT;
  localparam int PW = (FW > 1) ? $clog2(FW) : 1;
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CW-1:0] CNT_TC = CW'(BCLK_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FW - 1);
  localparam logic [PW-1:0] P_WS_LO = PW'(SLOT - 1);
  localparam logic [PW-1:0] P_WS_HI = PW'(FW - 2);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Serial bit for slot position pos: the frame is laid out as one FW-bit
  // word {left, pad, right, pad} and position 0 is its MSB.
  function automatic logic slot_bit(input logic [W-1:0]  l,
                                    input logic [W-1:0]  r,
                                    input logic [PW-1:0] pos);
    logic [FW-1:0] fw;
    logic [FW-1:0] sh;
    fw = ({{(FW-W){1'b0}}, l} << (FW - W)) |
         ({{(FW-W){1'b0}}, r} << (SLOT - W));
    sh = fw << pos;
    return sh[FW-1];
  endfunction

  // Word select leads the data by one BCLK: it rises one slot before the
  // right MSB and falls one slot before the left MSB.
  function automatic logic ws_of(input logic [PW-1:0] pos);
    return (pos >= P_WS_LO) && (pos <= P_WS_HI);
  endfunction

  // Bit clock divider
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          fall;

  assign cnt_tc = (cnt == CNT_TC);
  assign fall   = cnt_tc && i2s_bclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      i2s_bclk <= 1'b0;
    end else if (cnt_tc) begin
      cnt      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Slot position and frame boundary
  logic [PW-1:0] p;
  logic [PW-1:0] p_next;
  logic          frame_start;

  assign p_next      = (p == P_LAST) ? '0 : p + PW'(1);
  assign frame_start = fall && (p_next == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= P_LAST;
    end else if (fall) begin
      p <= p_next;
    end
  end

  // Frame FIFO
  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           push;
  logic           ovf_set;
  logic           unf_set;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_FULL);
  assign pop        = frame_start && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO at a
  // frame start is still accepted.
  assign push       = in_valid && (!fifo_full || pop);
  assign ovf_set    = in_valid && fifo_full && !pop;
  assign unf_set    = frame_start && fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame holding registers: loaded once per frame and indexed by p, so
  // after a pop they also hold the last popped pair.
  logic signed [W-1:0] l_hold;
  logic signed [W-1:0] r_hold;
  logic signed [W-1:0] ld_l;
  logic signed [W-1:0] ld_r;
  logic signed [W-1:0] cur_l;
  logic signed [W-1:0] cur_r;

`ifdef PCM_I2S_TX_REPEAT_EN
  // Set once any pair has been popped since reset; until then an underflow
  // repeats silence rather than stale register contents.
  logic have_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      have_last <= 1'b0;
    end else if (pop) begin
      have_last <= 1'b1;
    end
  end

  always_comb begin
    ld_l = '0;
    ld_r = '0;
    if (!fifo_empty) begin
      {ld_l, ld_r} = mem[rd_ptr];
    end else if (have_last) begin
      ld_l = l_hold;
      ld_r = r_hold;
    end
  end
`else
  always_comb begin
    ld_l = '0;
    ld_r = '0;
    if (!fifo_empty) begin
      {ld_l, ld_r} = mem[rd_ptr];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (frame_start) begin
      l_hold <= ld_l;
      r_hold <= ld_r;
    end
  end

  // The bit driven at the frame-start fall event must come from the pair
  // being loaded in that same cycle.
  assign cur_l = frame_start ? ld_l : l_hold;
  assign cur_r = frame_start ? ld_r : r_hold;

  // Serial outputs, updated only on BCLK falling edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i2s_lrclk <= 1'b0;
      i2s_sd    <= 1'b0;
    end else if (fall) begin
      i2s_lrclk <= ws_of(p_next);
      i2s_sd    <= slot_bit(cur_l, cur_r, p_next);
    end
  end

  // Sticky flags, set-dominant over clr_flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (unf_set)        underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

endmodule
